// File: rtl/taylor_ln_pkg.sv
// taylor_ln_pkg -- shared definitions for the iterative ln(x) Taylor evaluator.
//   state_t      : controller states IDLE/PREP/ITER/DONE
//   QNAN         : canonical quiet NaN returned on a domain error
//   RECIP[2..16] : single-precision 1/k coefficients (entries 0,1 unused)
//   fp_add/fp_mul: single-precision ADD and MUL units (round to nearest even,
//                  denormals flushed to zero, overflow saturates to infinity)
package taylor_ln_pkg;

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [31:0] RECIP [0:16] = '{
    32'h00000000, 32'h3F800000, 32'h3F000000, 32'h3EAAAAAB,
    32'h3E800000, 32'h3E4CCCCD, 32'h3E2AAAAB, 32'h3E124925,
    32'h3E000000, 32'h3DE38E39, 32'h3DCCCCCD, 32'h3DBA2E8C,
    32'h3DAAAAAB, 32'h3D9D89D9, 32'h3D924925, 32'h3D888889,
    32'h3D800000
  };

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [24:0] m;
    logic        g, st;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == '0 || b[30:23] == '0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, sh;
    logic [27:0] sum;
    logic [24:0] m;
    logic        g, st;
    int          e;
    int unsigned d;
    // x carries the larger magnitude, so the result sign is x's sign
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    if (y[30:23] == '0) return x;
    e  = int'(x[30:23]);
    d  = 32'(x[30:23]) - 32'(y[30:23]);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // alignment shift folds every bit shifted out into the sticky bit
    if (d > 26) sh = 27'd1;
    else begin
      sh = my >> d;
      if ((my & ((27'd1 << d) - 27'd1)) != '0) sh[0] = 1'b1;
    end
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 1; end
    end else begin
      sum = {1'b0, mx} - {1'b0, sh};
      if (sum == '0) return '0;
      for (int unsigned i = 0; i < 26; i++)
        if (!sum[26]) begin sum = sum << 1; e = e - 1; end
    end
    m  = {1'b0, sum[26:3]};
    g  = sum[2];
    st = |sum[1:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/taylor_ln_iter_if.sv
// taylor_ln_iter_if -- operand/result handshake bundle for taylor_ln_iter.
//   in, in_valid, in_ready        : operand channel (x, IEEE754 single)
//   out, out_valid, out_ready, err: result channel (ln(x), domain error flag)
//   slave modport is the evaluator side, master modport the client side.
interface taylor_ln_iter_if;
  logic [31:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  modport master (output in, in_valid, out_ready,
                  input  in_ready, out, out_valid, err);
  modport slave  (input  in, in_valid, out_ready,
                  output in_ready, out, out_valid, err);
endinterface

// File: rtl/taylor_ln_step.sv
// taylor_ln_step -- one combinational Taylor iteration.
//   pow, u, acc : current power u^(k-1), normalised offset u, running sum
//   k           : index of the term being added (2..N_TERMS)
//   pow_next    : pow*u
//   acc_next    : acc - pow_next/k for even k, acc + pow_next/k for odd k
//   last        : this iteration is the final one
// Macro TAYLOR_LN_EARLY_EXIT_EN: also flag last once the term falls below
// half an ulp of the accumulator.
module taylor_ln_step
  import taylor_ln_pkg::*;
#(
  parameter int N_TERMS = 10
) (
  input  logic [31:0] pow,
  input  logic [31:0] u,
  input  logic [31:0] acc,
  input  logic [4:0]  k,
  output logic [31:0] pow_next,
  output logic [31:0] acc_next,
  output logic        last
);
  logic [31:0] term;

  always_comb begin
    pow_next = fp_mul(pow, u);
    term     = fp_mul(pow_next, RECIP[k]);
    acc_next = fp_add(acc, k[0] ? term : {~term[31], term[30:0]});
    last     = (k == 5'(N_TERMS));
`ifdef TAYLOR_LN_EARLY_EXIT_EN
    if ({1'b0, term[30:23]} + 9'd24 < {1'b0, acc_next[30:23]}) last = 1'b1;
`else
`endif
  end
endmodule

// File: rtl/taylor_ln_iter.sv
// taylor_ln_iter -- iterative ln(x) by Taylor expansion of ln(A(1+u)),
// u = (x-A)/A, summing N_TERMS terms one per cycle.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus.slave  : operand in/in_valid/in_ready, result out/out_valid/out_ready/err
// Parameters N_TERMS (2..16), A_CENTER, LN_A = ln(A_CENTER), INV_A = 1/A_CENTER.
// Macro TAYLOR_LN_EARLY_EXIT_EN enables early termination on negligible terms.
module taylor_ln_iter
  import taylor_ln_pkg::*;
#(
  parameter int          N_TERMS  = 10,
  parameter logic [31:0] A_CENTER = 32'h3EC00000,
  parameter logic [31:0] LN_A     = 32'hBF7B17A0,
  parameter logic [31:0] INV_A    = 32'h402AAAAB
) (
  input logic             clk,
  input logic             rst_n,
  taylor_ln_iter_if.slave bus
);
  state_t      state;
  logic [31:0] x, u, pow, acc;
  logic [4:0]  k;
  logic [31:0] u_prep, acc_prep;
  logic [31:0] pow_next, acc_next;
  logic        last;

  always_comb begin
    u_prep   = fp_mul(fp_add(x, {~A_CENTER[31], A_CENTER[30:0]}), INV_A);
    acc_prep = fp_add(LN_A, u_prep);
  end

  taylor_ln_step #(.N_TERMS(N_TERMS)) step (
    .pow      (pow),
    .u        (u),
    .acc      (acc),
    .k        (k),
    .pow_next (pow_next),
    .acc_next (acc_next),
    .last     (last)
  );

  // in_ready is a register that tracks state==IDLE exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      u             <= '0;
      pow           <= '0;
      acc           <= '0;
      k             <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x            <= bus.in;
          bus.in_ready <= 1'b0;
          state        <= PREP;
        end
        PREP: begin
          if (x[31] || x[30:0] == '0 || x[30:23] == 8'hFF) begin
            bus.out       <= QNAN;
            bus.err       <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (x[30:0] == A_CENTER[30:0]) begin
            bus.out       <= LN_A;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            u     <= u_prep;
            pow   <= u_prep;
            acc   <= acc_prep;
            k     <= 5'd2;
            state <= ITER;
          end
        end
        ITER: begin
          pow <= pow_next;
          acc <= acc_next;
          k   <= k + 5'd1;
          if (last) begin
            bus.out       <= acc_next;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/taylor_ln_iter.md
TAYLOR_LN_ITER -- requirements
Module: taylor_ln_iter

Interface
REQ-001 Parameter N_TERMS, default 10: number of Taylor terms summed, legal 2..16.
REQ-002 Parameter A_CENTER, default 32'h3EC00000 (0.375): expansion point, IEEE754 single.
REQ-003 Parameter LN_A, default 32'hBF7B17A0: ln(A_CENTER), single.
REQ-004 Parameter INV_A, default 32'h402AAAAB (1/0.375): reciprocal of A_CENTER, single.
REQ-005 clk  input  1  rising-edge clock, sole clock domain.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in  input  32  operand x, IEEE754 single.
REQ-008 in_valid  input  1  operand present.
REQ-009 in_ready  output  1  block accepts operand.
REQ-010 out  output  32  ln(x), IEEE754 single.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 err  output  1  domain error on current result, qualified by out_valid.

Function
REQ-014 FSM states IDLE, PREP, ITER, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept when in_valid & in_ready: latch x, go to PREP.
REQ-016 Domain check in PREP: x sign=1 or x[30:0]==0 or x exponent==8'hFF -> out=32'h7FC00000, err=1, go to DONE.
REQ-017 Bypass in PREP: x[30:0]==A_CENTER[30:0] with sign 0 -> out=LN_A, err=0, go to DONE.
REQ-018 Otherwise PREP computes u=(x-A_CENTER)*INV_A, pow=u, acc=LN_A+u, k=2, go to ITER.
REQ-019 Each ITER cycle: pow=pow*u; term=pow*RECIP[k]; acc=acc+term for even k... SHALL be acc-term for even k, acc+term for odd k; k=k+1.
REQ-020 Leave ITER to DONE after iteration k==N_TERMS; out=acc, err=0.
REQ-021 Latency accept->out_valid: 2 cycles for error/bypass, N_TERMS+1 cycles for normal path (N_TERMS+1 = 11 at default).
REQ-022 In DONE out_valid=1; out and err SHALL hold stable until out_ready=1, then return to IDLE next cycle.
REQ-023 No new operand accepted while out_valid=1; no result dropped under back-pressure.
REQ-024 All arithmetic SHALL use the team's ADD and MUL single-precision units; no division in datapath.

Reset
REQ-025 rst_n=0 at a clock edge: state=IDLE, out=0, out_valid=0, err=0, in_ready=1 next cycle.
REQ-026 Reset mid-ITER or mid-DONE SHALL abandon the operation; no result emitted afterwards.

Configuration
REQ-027 Macro TAYLOR_LN_EARLY_EXIT_EN: when defined, ITER SHALL go to DONE early once term exponent < acc exponent - 24 (term below half-ulp of acc), latency then variable but >= 3.
REQ-028 Without TAYLOR_LN_EARLY_EXIT_EN, ITER SHALL always run exactly N_TERMS-1 iterations.

Structure
REQ-029 Shared package taylor_ln_pkg holds RECIP[2..16] (single-precision 1/k constants), QNAN=32'h7FC00000, state enum.
REQ-030 One sub-module taylor_ln_step: combinational pow*u, pow*RECIP[k], signed accumulate (two MUL, one ADD).
REQ-031 Registers (pow, u, acc, k, state) live in taylor_ln_iter only.

Verification
REQ-032 in=32'h3EC00000 -> out=32'hBF7B17A0, err=0, out_valid 2 cycles after accept.
REQ-033 in=32'h3F000000 (0.5) -> out within 1e-5 of -0.693147 (32'hBF317218), err=0, 11 cycles at default.
REQ-034 in=32'hBF800000 and in=32'h00000000 -> out=32'h7FC00000, err=1, latency 2.
REQ-035 out_ready held 0 for 5 cycles after out_valid -> out, err constant, in_ready=0 throughout; handshake completes on cycle out_ready=1.
REQ-036 rst_n=0 for one edge at ITER k=5 -> out_valid=0, in_ready=1 next cycle; following operand 0.5 gives correct result.
REQ-037 N_TERMS=4 build, in=0.5 -> out_valid 5 cycles after accept; with TAYLOR_LN_EARLY_EXIT_EN, in=0.37500003 exits before k=N_TERMS.
